// File: rtl/trace_feeder_pkg.sv
// -----------------------------------------------------------------------------
// trace_feeder_pkg
//   Shared definitions for the trace feeder and its trace ROM.
//   - TRACE_W   : width of one trace entry (a 16-bit memory address)
//   - state_e   : feeder FSM encoding, exposed for debug as well
//   - sat_inc16 : 16-bit increment that sticks at all-ones
// -----------------------------------------------------------------------------
package trace_feeder_pkg;

   localparam int TRACE_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_ISSUE     = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_DONE      = 3'd4
   } state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/trace_rom.sv
// -----------------------------------------------------------------------------
// trace_rom
//   Synchronous single-port trace ROM, one-cycle read latency.
//   Contents come from the INIT parameter (entry i at INIT[i*16 +: 16]); a
//   build flow normally generates INIT from the trace hex file. Addresses at
//   or beyond TRACE_DEPTH read as zero.
//
//   Ports:
//     clk     in  clock
//     addr_i  in  ADDR_W  read address
//     data_o  out 16      registered read data, valid one cycle after addr_i
// -----------------------------------------------------------------------------
module trace_rom
   import trace_feeder_pkg::*;
#(
   parameter int                             TRACE_DEPTH = 1024,
   parameter int                             ADDR_W      = 10,
   parameter logic [TRACE_DEPTH*TRACE_W-1:0] INIT        = '0
) (
   input  logic               clk,
   input  logic [ADDR_W-1:0]  addr_i,
   output logic [TRACE_W-1:0] data_o
);

   localparam int ROM_N = 1 << ADDR_W;

   logic [TRACE_W-1:0] rom_mem [ROM_N];
   logic [TRACE_W-1:0] data_q;

   // Pad the array to a power of two so every address is a legal index.
   for (genvar i = 0; i < ROM_N; i++) begin : g_rom
      if (i < TRACE_DEPTH) begin : g_used
         assign rom_mem[i] = INIT[i*TRACE_W +: TRACE_W];
      end else begin : g_pad
         assign rom_mem[i] = '0;
      end
   end

   always_ff @(posedge clk) begin
      data_q <= rom_mem[addr_i];
   end

   assign data_o = data_q;

endmodule

// File: rtl/trace_feeder.sv
// -----------------------------------------------------------------------------
// trace_feeder
//   Walks a trace ROM sequentially and hands each 16-bit address to the cache.
//   One access is outstanding at a time: the address is presented on
//   memory_trace together with a one-cycle trace_ready strobe, and the next
//   entry is fetched only after the cache pulses access_done.
//
//   Handshake: trace_ready is a single-cycle strobe; memory_trace is valid in
//   that cycle and stays stable until the cache's access_done pulse has been
//   accepted. access_done is only honoured in WAIT_DONE; a pulse anywhere
//   else is dropped.
//
//   Ports:
//     clk, reset     in       clock, synchronous active-high reset
//     start          in       level; starts a run from entry 0 when idle
//     loop_en        in       wrap to entry 0 after the last entry
//     rom_addr       out ADDR_W  trace ROM read address
//     rom_data       in  16   trace ROM data, one cycle after rom_addr
//     memory_trace   out 16   address presented to the cache
//     trace_ready    out      one-cycle strobe per access
//     access_done    in       cache completion pulse
//     access_count   out 16   completed accesses, saturating
//     busy_cycles    out 32   cycles spent waiting on the cache, wrapping
//     trace_end      out      high while in DONE
//     stall_err      out      sticky timeout flag
//     dbg_state      out      current FSM state
//
//   Timing: rom_addr changes on entry to FETCH; the ROM data is valid during
//   ISSUE, where it is captured, so memory_trace and trace_ready appear in
//   the first WAIT_DONE cycle, two cycles after rom_addr changed.
// -----------------------------------------------------------------------------
module trace_feeder
   import trace_feeder_pkg::*;
#(
   parameter int TRACE_DEPTH = 1024,
   parameter int ADDR_W      = 10,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               loop_en,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [TRACE_W-1:0] rom_data,
   output logic [TRACE_W-1:0] memory_trace,
   output logic               trace_ready,
   input  logic               access_done,
   output logic [15:0]        access_count,
   output logic [31:0]        busy_cycles,
   output logic               trace_end,
   output logic               stall_err,
   output state_e             dbg_state
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TRACE_DEPTH - 1);
   localparam logic [15:0]       TMO_LAST  = 16'(TIMEOUT_CYC - 1);

   state_e             state_q,        state_d;
   logic [ADDR_W-1:0]  rom_addr_q,     rom_addr_d;
   logic [TRACE_W-1:0] mem_trace_q,    mem_trace_d;
   logic               trace_ready_q,  trace_ready_d;
   logic [15:0]        acc_cnt_q,      acc_cnt_d;
   logic [31:0]        busy_q,         busy_d;
   logic               trace_end_q,    trace_end_d;
   logic               stall_q,        stall_d;
   logic [15:0]        tmo_q,          tmo_d;

   always_comb begin
      state_d       = state_q;
      rom_addr_d    = rom_addr_q;
      mem_trace_d   = mem_trace_q;
      trace_ready_d = 1'b0;
      acc_cnt_d     = acc_cnt_q;
      busy_d        = busy_q;
      trace_end_d   = trace_end_q;
      stall_d       = stall_q;
      tmo_d         = tmo_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_FETCH;
               rom_addr_d  = '0;
               acc_cnt_d   = '0;
               busy_d      = '0;
               stall_d     = 1'b0;
               trace_end_d = 1'b0;
            end
         end

         // Pure latency slot: the ROM is reading rom_addr_q this cycle.
         ST_FETCH: begin
            state_d = ST_ISSUE;
         end

         ST_ISSUE: begin
            mem_trace_d   = rom_data;
            trace_ready_d = 1'b1;
            tmo_d         = '0;
            state_d       = ST_WAIT_DONE;
         end

         ST_WAIT_DONE: begin
            busy_d = busy_q + 32'd1;
            tmo_d  = tmo_q + 16'd1;
            // access_done is checked first so it wins over a same-cycle timeout.
            if (access_done) begin
               acc_cnt_d = sat_inc16(acc_cnt_q);
               if (rom_addr_q != LAST_ADDR) begin
                  rom_addr_d = rom_addr_q + ADDR_W'(1);
                  state_d    = ST_FETCH;
               end else if (loop_en) begin
                  rom_addr_d = '0;
                  state_d    = ST_FETCH;
               end else begin
                  trace_end_d = 1'b1;
                  state_d     = ST_DONE;
               end
            end else if (tmo_q == TMO_LAST) begin
               // This is the TIMEOUT_CYC-th cycle without a completion.
               stall_d     = 1'b1;
               trace_end_d = 1'b1;
               state_d     = ST_DONE;
            end
         end

         // Held until start drops so a level-high start cannot auto-restart.
         ST_DONE: begin
            if (!start) begin
               trace_end_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         rom_addr_q    <= '0;
         mem_trace_q   <= '0;
         trace_ready_q <= 1'b0;
         acc_cnt_q     <= '0;
         busy_q        <= '0;
         trace_end_q   <= 1'b0;
         stall_q       <= 1'b0;
         tmo_q         <= '0;
      end else begin
         state_q       <= state_d;
         rom_addr_q    <= rom_addr_d;
         mem_trace_q   <= mem_trace_d;
         trace_ready_q <= trace_ready_d;
         acc_cnt_q     <= acc_cnt_d;
         busy_q        <= busy_d;
         trace_end_q   <= trace_end_d;
         stall_q       <= stall_d;
         tmo_q         <= tmo_d;
      end
   end

   assign rom_addr     = rom_addr_q;
   assign memory_trace = mem_trace_q;
   assign trace_ready  = trace_ready_q;
   assign access_count = acc_cnt_q;
   assign busy_cycles  = busy_q;
   assign trace_end    = trace_end_q;
   assign stall_err    = stall_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_trace_feeder.sv
// -----------------------------------------------------------------------------
// tb_trace_feeder
//   Four-entry trace {0x0010, 0x8010, 0x0010, 0x0020}, TIMEOUT_CYC = 5.
//   Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_trace_feeder;
   import trace_feeder_pkg::*;

   localparam int TRACE_DEPTH = 4;
   localparam int ADDR_W      = 2;
   localparam int TIMEOUT_CYC = 5;
   localparam logic [TRACE_DEPTH*16-1:0] ROM_INIT =
      {16'h0020, 16'h0010, 16'h8010, 16'h0010};

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset;
   logic               start;
   logic               loop_en;
   logic               access_done;
   logic [ADDR_W-1:0]  rom_addr;
   logic [15:0]        rom_data;
   logic [15:0]        memory_trace;
   logic               trace_ready;
   logic [15:0]        access_count;
   logic [31:0]        busy_cycles;
   logic               trace_end;
   logic               stall_err;
   state_e             dbg_state;

   trace_rom #(
      .TRACE_DEPTH(TRACE_DEPTH), .ADDR_W(ADDR_W), .INIT(ROM_INIT)
   ) u_rom (
      .clk    (clk),
      .addr_i (rom_addr),
      .data_o (rom_data)
   );

   trace_feeder #(
      .TRACE_DEPTH(TRACE_DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .loop_en      (loop_en),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .memory_trace (memory_trace),
      .trace_ready  (trace_ready),
      .access_done  (access_done),
      .access_count (access_count),
      .busy_cycles  (busy_cycles),
      .trace_end    (trace_end),
      .stall_err    (stall_err),
      .dbg_state    (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [15:0] rom_model [4] = '{16'h0010, 16'h8010, 16'h0010, 16'h0020};
   logic [15:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_state(input state_e s, input string name);
      int n = 0;
      while (dbg_state != s && n < 20) begin
         tick();
         n++;
      end
      chk({name, "_reached"}, 32'(dbg_state == s), 32'd1);
   endtask

   task automatic wait_pulse(input string name);
      int n = 0;
      while (!trace_ready && n < 20) begin
         tick();
         n++;
      end
      chk({name, "_pulse"}, 32'(trace_ready), 32'd1);
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_state"},   32'(dbg_state),  32'(ST_IDLE));
      chk({pfx, "_rom_addr"}, 32'(rom_addr),  32'd0);
      chk({pfx, "_trace"},   32'(memory_trace), 32'd0);
      chk({pfx, "_ready"},   32'(trace_ready), 32'd0);
      chk({pfx, "_count"},   32'(access_count), 32'd0);
      chk({pfx, "_busy"},    busy_cycles,     32'd0);
      chk({pfx, "_end"},     32'(trace_end),  32'd0);
      chk({pfx, "_stall"},   32'(stall_err),  32'd0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string       name;
      logic        loop_en;
      int          drop_after;  // clear loop_en after this many pulses (0 = never)
      int          done_lag;    // access_done sampled at the Nth edge after trace_ready (0 = never)
      int          exp_pulses;
      logic [15:0] exp_count;
      logic [31:0] exp_busy;
      logic        exp_stall;
   } run_vec_t;

   run_vec_t vecs [6];

   // Driver + checker for one whole run, ending with start held through DONE.
   task automatic run_vec(input run_vec_t v);
      int pulses = 0;
      int cnt    = -1;
      int cyc    = 0;
      bit ended  = 1'b0;
      int extra  = 0;
      exp_q.delete();
      loop_en = v.loop_en;
      start   = 1'b1;
      tick();
      while (!ended && cyc < 300) begin
         access_done = 1'b0;
         if (trace_ready) begin
            if (exp_q.size() == 0) exp_q.push_back(rom_model[pulses % 4]);
            chk($sformatf("%s_trace%0d", v.name, pulses), 32'(memory_trace), 32'(exp_q.pop_front()));
            chk($sformatf("%s_addr%0d", v.name, pulses), 32'(rom_addr), 32'(pulses % 4));
            pulses++;
            if (pulses == v.drop_after) loop_en = 1'b0;
            if (v.done_lag > 0) cnt = v.done_lag - 1;
         end
         if (cnt == 0) begin
            access_done = 1'b1;
            cnt = -1;
         end else if (cnt > 0) begin
            cnt--;
         end
         if (trace_end) ended = 1'b1;
         else begin
            tick();
            cyc++;
         end
      end
      access_done = 1'b0;
      chk({v.name, "_ended"},  32'(ended),        32'd1);
      chk({v.name, "_pulses"}, 32'(pulses),       32'(v.exp_pulses));
      chk({v.name, "_count"},  32'(access_count), 32'(v.exp_count));
      chk({v.name, "_busy"},   busy_cycles,       v.exp_busy);
      chk({v.name, "_stall"},  32'(stall_err),    32'(v.exp_stall));
      chk({v.name, "_state"},  32'(dbg_state),    32'(ST_DONE));
      // start still high: must stay parked in DONE.
      for (int i = 0; i < 4; i++) begin
         tick();
         if (trace_ready) extra++;
      end
      chk({v.name, "_hold_state"}, 32'(dbg_state), 32'(ST_DONE));
      chk({v.name, "_hold_end"},   32'(trace_end),  32'd1);
      chk({v.name, "_hold_nopulse"}, 32'(extra),    32'd0);
      start   = 1'b0;
      loop_en = 1'b0;
      tick();
      chk({v.name, "_idle_state"}, 32'(dbg_state),    32'(ST_IDLE));
      chk({v.name, "_idle_end"},   32'(trace_end),    32'd0);
      chk({v.name, "_idle_count"}, 32'(access_count), 32'(v.exp_count));
   endtask

   // ---------------- test ----------------
   initial begin
      int stray;
      vecs[0] = '{"basic",  1'b0, 0, 3, 4, 16'd4, 32'd12, 1'b0};
      vecs[1] = '{"loop",   1'b1, 5, 3, 8, 16'd8, 32'd24, 1'b0};
      vecs[2] = '{"tmo",    1'b0, 0, 0, 1, 16'd0, 32'd5,  1'b1};
      vecs[3] = '{"lag1",   1'b0, 0, 1, 4, 16'd4, 32'd4,  1'b0};
      vecs[4] = '{"lag4",   1'b0, 0, 4, 4, 16'd4, 32'd16, 1'b0};
      vecs[5] = '{"lag5",   1'b0, 0, 5, 4, 16'd4, 32'd20, 1'b0};

      reset = 1'b1; start = 1'b0; loop_en = 1'b0; access_done = 1'b0;
      tick();
      tick();
      chk_reset_vals("rst");
      reset = 1'b0;
      tick();
      chk("rst_idle_hold", 32'(dbg_state), 32'(ST_IDLE));

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Spurious done in IDLE: nothing moves, count holds from last run.
      access_done = 1'b1;
      tick();
      access_done = 1'b0;
      tick();
      chk("spur_idle_state", 32'(dbg_state),    32'(ST_IDLE));
      chk("spur_idle_count", 32'(access_count), 32'd4);

      // Spurious done in the ISSUE cycle must not complete the access.
      start = 1'b1;
      wait_state(ST_ISSUE, "spur_issue");
      access_done = 1'b1;
      tick();
      access_done = 1'b0;
      chk("spur_issue_state", 32'(dbg_state),    32'(ST_WAIT_DONE));
      chk("spur_issue_ready", 32'(trace_ready),  32'd1);
      chk("spur_issue_count", 32'(access_count), 32'd0);
      tick();
      chk("spur_issue_still", 32'(dbg_state),    32'(ST_WAIT_DONE));
      chk("spur_issue_addr",  32'(rom_addr),     32'd0);
      reset = 1'b1;
      start = 1'b0;
      tick();
      reset = 1'b0;

      // Reset during WAIT_DONE of the second access.
      start = 1'b1;
      wait_pulse("mid_a1");
      access_done = 1'b1;
      tick();
      access_done = 1'b0;
      wait_pulse("mid_a2");
      chk("mid_a2_trace", 32'(memory_trace), 32'h8010);
      chk("mid_a2_count", 32'(access_count), 32'd1);
      reset = 1'b1;
      start = 1'b0;
      tick();
      chk_reset_vals("mid_rst");
      reset = 1'b0;
      stray = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (trace_ready) stray++;
      end
      chk("mid_no_pulse", 32'(stray), 32'd0);
      chk("mid_idle",     32'(dbg_state), 32'(ST_IDLE));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
